rgb_led_arbiter: RTL

- Shares the single on-board RGB LED between N_REQ status sources.
- Round-robin arbitration with a guaranteed minimum display time per grant, so each source's colour is visible to a human.
- Optional per-source blink and a dark gap between owners.
- Sits between system status logic (requesters) and the LED_RGB pins; replaces direct decoder-to-pin drive.

---
 rtl/rgb_led_arb_pkg.sv | 45 ++++
 rtl/rgb_led_arbiter_tick_gen.sv | 29 ++
 rtl/rgb_led_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rgb_led_arb_pkg.sv
// Shared types, colour constants and round-robin helper
// for the RGB LED arbiter.
package rgb_led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    GAP
  } state_t;

  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_R   = 3'b100;
  localparam logic [2:0] LED_G   = 3'b010;
  localparam logic [2:0] LED_B   = 3'b001;
  localparam logic [2:0] LED_W   = 3'b111;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req searching from ptr+1 upward, modulo n.
  function automatic pick_t rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    pick_t      p;
    int         j;
    logic [2:0] jj;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j  = (int'(ptr) + k) % n;
      jj = 3'(j);
      if (k <= n && !p.valid && req[jj]) begin
        p.valid = 1'b1;
        p.idx   = jj;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rgb_led_arbiter_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks;
// clr restarts the count so a tenure starts on a tick boundary.
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the on-board RGB LED with a minimum
// dwell per grant, optional blink and a dark gap between owners.
module rgb_led_arbiter
  import rgb_led_arb_pkg::*;
#(
  parameter int N_REQ           = 3,
  parameter int TICK_DIV        = 12_500_000,
  parameter int MIN_DWELL_TICKS = 10
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [3*N_REQ-1:0] REQ_RGB,
  input  logic [N_REQ-1:0]   REQ_BLINK,
  output logic [N_REQ-1:0]   GNT,
  output logic [2:0]         LED_RGB,
  output logic               BUSY
);

  localparam int IW = $clog2(N_REQ);
  localparam int DW = $clog2(MIN_DWELL_TICKS) + 1;
  localparam logic [DW-1:0] DW_LAST = DW'(MIN_DWELL_TICKS - 1);

  logic [1:0]    rst_sync;
  logic          run;
  logic          tick;
  logic          clr;
  logic          grant;
  pick_t         pick;

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [2:0]    col, col_n;
  logic          blk, blk_n;
  logic          phase, phase_n;
  logic [DW-1:0] dwell, dwell_n;

  logic [N_REQ-1:0] gnt_d;
  logic [2:0]       led_d;
  logic             busy_d;

  logic [2:0] rgb_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_rgb
    assign rgb_arr[g] = REQ_RGB[3*g +: 3];
  end

  // Release is held off two cycles so the FSM never wakes
  // on a partially released reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run  = rst_sync[1];
  assign pick = rr_pick(8'(REQ), 3'(ptr), N_REQ);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    col_n   = col;
    blk_n   = blk;
    phase_n = phase;
    dwell_n = dwell;
    grant   = 1'b0;
    clr     = 1'b0;

    unique case (state)
      IDLE: begin
        if (run && pick.valid) grant = 1'b1;
      end
      SERVE: begin
        if (tick) begin
          if (dwell == DW_LAST) begin
            if (!pick.valid) begin
              state_n = IDLE;
            end else if (IW'(pick.idx) != owner) begin
              state_n = GAP;
              clr     = 1'b1;
            end else begin
              grant = 1'b1;
            end
          end else begin
            dwell_n = dwell + DW'(1);
            phase_n = ~phase;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (pick.valid) grant = 1'b1;
          else            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant) begin
      state_n = SERVE;
      clr     = 1'b1;
      owner_n = IW'(pick.idx);
      ptr_n   = owner_n;
      col_n   = rgb_arr[owner_n];
      blk_n   = REQ_BLINK[owner_n];
      phase_n = 1'b0;
      dwell_n = '0;
    end

    gnt_d  = '0;
    led_d  = LED_OFF;
    busy_d = (state_n != IDLE);
    if (state_n == SERVE) begin
      gnt_d[owner_n] = 1'b1;
      if (!(blk_n && phase_n)) led_d = col_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= IW'(N_REQ - 1);
      col     <= LED_OFF;
      blk     <= 1'b0;
      phase   <= 1'b0;
      dwell   <= '0;
      GNT     <= '0;
      LED_RGB <= LED_OFF;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      col     <= col_n;
      blk     <= blk_n;
      phase   <= phase_n;
      dwell   <= dwell_n;
      GNT     <= gnt_d;
      LED_RGB <= led_d;
      BUSY    <= busy_d;
    end
  end

endmodule
